ex_commit: RTL and testbench



---
 rtl/ex_commit_if.sv | 29 ++
 rtl/ex_commit.sv | 151 +++++++++++++++
 tb/tb_ex_commit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_commit_if.sv
// Handshake and writeback bundle between the ALU/long-latency producers, ex_commit and the register file.
interface ex_commit_if;
  localparam int unsigned RN_W   = 6;
  localparam int unsigned DATA_W = 64;

  logic              alu_valid;
  logic [RN_W-1:0]   alu_rn;
  logic [DATA_W-1:0] alu_data;
  logic              stall;
  logic              mul_valid;
  logic [RN_W-1:0]   mul_rn;
  logic [DATA_W-1:0] mul_data;
  logic              mul_ack;
  logic              rf_we;
  logic [RN_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              sb_clr;
  logic [RN_W-1:0]   sb_clr_rn;

  modport master (
    output alu_valid, alu_rn, alu_data, mul_valid, mul_rn, mul_data,
    input  stall, mul_ack, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rn
  );

  modport slave (
    input  alu_valid, alu_rn, alu_data, mul_valid, mul_rn, mul_data,
    output stall, mul_ack, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rn
  );
endinterface

// File: rtl/ex_commit.sv
// Writeback/commit stage: ALU result FIFO with bypass, ALU/mul write-port arbitration, stall and scoreboard release.
// Optional simulation checks are enabled with `define RAISIN64_COMMIT_CHECK_EN.
module ex_commit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_commit_if.slave  bus
);
  localparam int unsigned RN_W   = 6;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t               r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rr;

  logic              r_rf_we;
  logic [RN_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_sb_clr;
  logic [RN_W-1:0]   r_sb_clr_rn;

  logic              w_empty;
  logic              w_stall;
  logic              w_alu_cand;
  logic              w_contend;
  logic              w_grant_alu;
  logic              w_grant_mul;
  logic              w_pop;
  logic              w_push;
  wb_t               w_alu_wb;
  wb_t               w_wb;
  logic [CNT_W-1:0]  w_count_nxt;

  // Candidate selection and arbitration; the FIFO head always takes precedence over bypass.
  always_comb begin
    w_empty     = (r_count == '0);
    w_stall     = (r_count >= CNT_W'(DEPTH - 1));
    w_alu_cand  = !w_empty || bus.alu_valid;
    w_alu_wb.rn   = bus.alu_rn;
    w_alu_wb.data = bus.alu_data;
    if (!w_empty) begin
      w_alu_wb = r_fifo[r_rd_ptr];
    end
    w_contend   = w_alu_cand && bus.mul_valid;
    w_grant_alu = w_alu_cand && (!bus.mul_valid || w_stall || !r_rr);
    w_grant_mul = bus.mul_valid && !w_grant_alu;
    w_pop       = w_grant_alu && !w_empty;
    w_push      = bus.alu_valid && !(w_grant_alu && w_empty);
    w_wb.rn     = bus.mul_rn;
    w_wb.data   = bus.mul_data;
    if (w_grant_alu) begin
      w_wb = w_alu_wb;
    end
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Control state and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rr        <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_sb_clr    <= 1'b0;
      r_sb_clr_rn <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // rr points at the loser of a contended grant
      if (w_contend) begin
        r_rr <= w_grant_alu;
      end
      r_sb_clr <= w_grant_alu || w_grant_mul;
      r_rf_we  <= (w_grant_alu || w_grant_mul) && (w_wb.rn != '0);
      if (w_grant_alu || w_grant_mul) begin
        r_rf_waddr  <= w_wb.rn;
        r_rf_wdata  <= w_wb.data;
        r_sb_clr_rn <= w_wb.rn;
      end
    end
  end

  // FIFO storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{rn: bus.alu_rn, data: bus.alu_data};
    end
  end

  assign bus.stall     = w_stall;
  assign bus.mul_ack   = w_grant_mul && rst_n;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_rf_waddr;
  assign bus.rf_wdata  = r_rf_wdata;
  assign bus.sb_clr    = r_sb_clr;
  assign bus.sb_clr_rn = r_sb_clr_rn;

`ifdef RAISIN64_COMMIT_CHECK_EN
  logic              r_stall_d1;
  logic              r_stall_d2;
  logic              r_mul_pend;
  logic [RN_W-1:0]   r_mul_rn;
  logic [DATA_W-1:0] r_mul_data;

  // Protocol checks on the producers feeding this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_d1 <= 1'b0;
      r_stall_d2 <= 1'b0;
      r_mul_pend <= 1'b0;
      r_mul_rn   <= '0;
      r_mul_data <= '0;
    end else begin
      if (w_push && !w_pop && (r_count == CNT_W'(DEPTH))) begin
        $error("ex_commit: enqueue while FIFO full");
      end
      if (bus.alu_valid && r_stall_d1 && r_stall_d2) begin
        $error("ex_commit: alu_valid after two stalled cycles");
      end
      if (r_mul_pend && bus.mul_valid &&
          ((bus.mul_rn != r_mul_rn) || (bus.mul_data != r_mul_data))) begin
        $error("ex_commit: mul payload changed before ack");
      end
      r_stall_d1 <= w_stall;
      r_stall_d2 <= r_stall_d1;
      r_mul_pend <= bus.mul_valid && !w_grant_mul;
      r_mul_rn   <= bus.mul_rn;
      r_mul_data <= bus.mul_data;
    end
  end
`endif

endmodule

// File: tb/tb_ex_commit.sv
// Directed bench for ex_commit: expected writebacks queued by stimulus, popped and compared by a monitor.
module tb_ex_commit;
  typedef struct packed {
    logic        we;
    logic [5:0]  rn;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ack_cnt;
  exp_t exp_q[$];

  ex_commit_if bus ();

  ex_commit #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic expect_wb(input logic we, input logic [5:0] rn, input logic [63:0] d);
    exp_q.push_back(exp_t'({we, rn, d}));
  endtask

  task automatic step(input logic av, input logic [5:0] arn, input logic [63:0] ad, input logic mv);
    @(posedge clk);
    #1;
    bus.alu_valid = av;
    bus.alu_rn    = arn;
    bus.alu_data  = ad;
    bus.mul_valid = mv;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.mul_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: every scoreboard release must match the next expected writeback.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mul_ack) ack_cnt++;
      if (rst_n && bus.sb_clr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got rn %0d data %0h want none", bus.sb_clr_rn, bus.rf_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wb_we", 64'(bus.rf_we), 64'(e.we));
          chk("wb_waddr", 64'(bus.rf_waddr), 64'(e.rn));
          chk("wb_clr_rn", 64'(bus.sb_clr_rn), 64'(e.rn));
          chk("wb_data", bus.rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          ack_base;
    logic [12:0] st_exp;
    total = 0;
    bad = 0;
    ack_cnt = 0;
    rst_n = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rn    = '0;
    bus.alu_data  = '0;
    bus.mul_valid = 1'b0;
    bus.mul_rn    = 6'd9;
    bus.mul_data  = 64'hDEAD;
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_sb_clr", 64'(bus.sb_clr), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_mul_ack", 64'(bus.mul_ack), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_wdata", bus.rf_wdata, 64'd0);

    // Lone ALU result, bypass path, one-cycle latency
    do_reset();
    expect_wb(1'b1, 6'd5, 64'h1234);
    step(1'b1, 6'd5, 64'h1234, 1'b0);
    step(1'b0, 6'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("lone_rf_we", 64'(bus.rf_we), 64'd1);
    chk("lone_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("lone_wdata", bus.rf_wdata, 64'h1234);
    chk("lone_stall", 64'(bus.stall), 64'd0);
    wait_drain("lone_drain");

    // Contention: ALU and mul alternate through round-robin
    do_reset();
    ack_base = ack_cnt;
    expect_wb(1'b1, 6'd21, 64'hB001); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd22, 64'hB002); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd23, 64'hB003); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd24, 64'hB004); expect_wb(1'b1, 6'd9, 64'hDEAD);
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 6'(21 + i), 64'hB001 + 64'(i), 1'b1);
      @(negedge clk);
      chk("rr_stall", 64'(bus.stall), 64'd0);
    end
    step(1'b0, 6'd0, 64'd0, 1'b0);
    wait_drain("rr_drain");
    chk("rr_acks", 64'(ack_cnt - ack_base), 64'd4);

    // Fill: stall rises at occupancy 3, forced ALU grants keep order
    do_reset();
    ack_base = ack_cnt;
    st_exp = 13'h0C0;
    expect_wb(1'b1, 6'd11, 64'hA001); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd12, 64'hA002); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd13, 64'hA003); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd14, 64'hA004); expect_wb(1'b1, 6'd15, 64'hA005);
    expect_wb(1'b1, 6'd9, 64'hDEAD);  expect_wb(1'b1, 6'd16, 64'hA006);
    expect_wb(1'b1, 6'd9, 64'hDEAD);  expect_wb(1'b1, 6'd17, 64'hA007);
    expect_wb(1'b1, 6'd9, 64'hDEAD);
    for (int i = 0; i < 13; i++) begin
      step(i < 7, 6'(11 + i), 64'hA001 + 64'(i), 1'b1);
      @(negedge clk);
      chk("fill_stall", 64'(bus.stall), 64'(st_exp[i]));
    end
    step(1'b0, 6'd0, 64'd0, 1'b0);
    wait_drain("fill_drain");
    chk("fill_acks", 64'(ack_cnt - ack_base), 64'd6);

    // r0 destination: consumed from FIFO, no register write, scoreboard still released
    do_reset();
    ack_base = ack_cnt;
    bus.mul_rn   = 6'd7;
    bus.mul_data = 64'h77;
    expect_wb(1'b1, 6'd3, 64'h33); expect_wb(1'b1, 6'd7, 64'h77);
    expect_wb(1'b0, 6'd0, 64'hFF); expect_wb(1'b1, 6'd4, 64'h44);
    step(1'b1, 6'd3, 64'h33, 1'b1);
    step(1'b1, 6'd0, 64'hFF, 1'b1);
    step(1'b0, 6'd0, 64'd0, 1'b0);
    step(1'b1, 6'd4, 64'h44, 1'b0);
    @(negedge clk);
    chk("r0_rf_we", 64'(bus.rf_we), 64'd0);
    chk("r0_sb_clr", 64'(bus.sb_clr), 64'd1);
    chk("r0_clr_rn", 64'(bus.sb_clr_rn), 64'd0);
    step(1'b0, 6'd0, 64'd0, 1'b0);
    wait_drain("r0_drain");
    chk("r0_acks", 64'(ack_cnt - ack_base), 64'd1);
    bus.mul_rn   = 6'd9;
    bus.mul_data = 64'hDEAD;

    // Reset with three queued entries and a mul result still asserted
    do_reset();
    ack_base = ack_cnt;
    expect_wb(1'b1, 6'd31, 64'hC001); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd32, 64'hC002); expect_wb(1'b1, 6'd9, 64'hDEAD);
    expect_wb(1'b1, 6'd33, 64'hC003);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 6'(31 + i), 64'hC001 + 64'(i), 1'b1);
    end
    @(negedge clk);
    chk("mid_pre_q", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rf_we", 64'(bus.rf_we), 64'd0);
    chk("mid_sb_clr", 64'(bus.sb_clr), 64'd0);
    chk("mid_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("mid_wdata", bus.rf_wdata, 64'd0);
    chk("mid_clr_rn", 64'(bus.sb_clr_rn), 64'd0);
    chk("mid_stall", 64'(bus.stall), 64'd0);
    chk("mid_mul_ack", 64'(bus.mul_ack), 64'd0);
    @(negedge clk);
    chk("mid_acks", 64'(ack_cnt - ack_base), 64'd3);
    bus.mul_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_stall", 64'(bus.stall), 64'd0);
    expect_wb(1'b1, 6'd12, 64'hC0DE);
    step(1'b1, 6'd12, 64'hC0DE, 1'b0);
    step(1'b0, 6'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("post_rf_we", 64'(bus.rf_we), 64'd1);
    chk("post_waddr", 64'(bus.rf_waddr), 64'd12);
    chk("post_wdata", bus.rf_wdata, 64'hC0DE);
    wait_drain("post_drain");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
